// File: rtl/gin_pkg.sv
// Shared definitions for the global input network: broadcast ID, tag split
// helper and PE indexing used by the multicast match logic.
package gin_pkg;

    localparam int MAX_ID_BITS = 8;

    typedef logic [MAX_ID_BITS-1:0]   id_word_t;
    typedef logic [2*MAX_ID_BITS-1:0] tag_word_t;

    typedef struct packed {
        id_word_t row;
        id_word_t col;
    } tag_split_t;

    // All-ones ID of the given width; a tag field with this value hits every row/column.
    function automatic id_word_t bcast_id(input int id_bits);
        return id_word_t'((32'd1 << id_bits) - 32'd1);
    endfunction

    function automatic tag_split_t split_tag(input tag_word_t tag, input int id_bits);
        tag_split_t t;
        t.col = tag[MAX_ID_BITS-1:0] & bcast_id(id_bits);
        t.row = id_word_t'(tag >> id_bits) & bcast_id(id_bits);
        return t;
    endfunction

    function automatic int pe_index(input int r, input int c, input int col_num);
        return r * col_num + c;
    endfunction

endpackage

// File: rtl/gin_mcast_net_if.sv
// Bundle of the GLB-side push port, scan-chain port and PE-side delivery port
// of the global input network.
interface gin_mcast_net_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ROW_NUM       = 6,
    parameter int COL_NUM       = 6,
    parameter int ID_BITWIDTH   = 3,
    parameter int FIFO_DEPTH    = 4
);
    logic                           cfg_en;
    logic [ID_BITWIDTH-1:0]         cfg_data;
    logic                           valid;
    logic [DATA_BITWIDTH-1:0]       data;
    logic [2*ID_BITWIDTH-1:0]       tag;
    logic                           ready;
    logic [ROW_NUM*COL_NUM-1:0]     pe_valid;
    logic [DATA_BITWIDTH-1:0]       pe_data;
    logic [ROW_NUM*COL_NUM-1:0]     pe_ready;
    logic                           drop;
    logic [$clog2(FIFO_DEPTH):0]    count;

    modport master (
        output cfg_en, cfg_data, valid, data, tag, pe_ready,
        input  ready, pe_valid, pe_data, drop, count
    );

    modport slave (
        input  cfg_en, cfg_data, valid, data, tag, pe_ready,
        output ready, pe_valid, pe_data, drop, count
    );

endinterface

// File: rtl/gin_fifo.sv
// Synchronous FIFO with valid/ready on both sides and an occupancy count.
// A push is refused while full even if the same cycle pops.
module gin_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = i_valid & ~full;
    assign pop   = i_ready & ~empty;

    // DEPTH is a power of two, so pointers wrap naturally on overflow.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    assign o_ready = ~full;
    assign o_valid = ~empty;
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/gin_mcast_net.sv
// Global input network: input FIFO feeding a row/column multicast tree whose
// controller IDs are loaded through a serial scan chain.
module gin_mcast_net
    import gin_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ROW_NUM       = 6,
    parameter int COL_NUM       = 6,
    parameter int ID_BITWIDTH   = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    gin_mcast_net_if.slave bus
);
    localparam int       N_PE   = ROW_NUM * COL_NUM;
    localparam int       N_IDS  = ROW_NUM * (COL_NUM + 1);
    localparam int       WORD_W = 2 * ID_BITWIDTH + DATA_BITWIDTH;
    localparam id_word_t BCAST  = bcast_id(ID_BITWIDTH);

    logic                     head_valid;
    logic                     head_ready;
    logic [WORD_W-1:0]        head_word;
    logic [2*ID_BITWIDTH-1:0] head_tag;
    tag_split_t               head_split;
    logic [ROW_NUM-1:0]       row_match;
    logic [N_PE-1:0]          mask;
    logic                     deliver;

    gin_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.valid),
        .i_data  ({bus.tag, bus.data}),
        .o_ready (bus.ready),
        .o_valid (head_valid),
        .o_data  (head_word),
        .i_ready (head_ready),
        .o_count (bus.count)
    );

    // Entries below N_PE are column IDs of each PE; the last ROW_NUM are row IDs.
    for (genvar k = 0; k < N_IDS; k++) begin : g_chain
        localparam logic [ID_BITWIDTH-1:0] RESET_ID =
            (k < N_PE) ? ID_BITWIDTH'(k % COL_NUM) : ID_BITWIDTH'(k - N_PE);
        logic [ID_BITWIDTH-1:0] id;

        if (k == 0) begin : g_head
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst)          id <= RESET_ID;
                else if (bus.cfg_en) id <= bus.cfg_data;
            end
        end else begin : g_link
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst)          id <= RESET_ID;
                else if (bus.cfg_en) id <= g_chain[k-1].id;
            end
        end
    end

    assign head_tag   = head_word[WORD_W-1:DATA_BITWIDTH];
    assign head_split = split_tag(tag_word_t'(head_tag), ID_BITWIDTH);

    for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
        assign row_match[r] = (head_split.row == BCAST) ||
                              (head_split.row == id_word_t'(g_chain[N_PE + r].id));
        for (genvar c = 0; c < COL_NUM; c++) begin : g_col
            localparam int PE = pe_index(r, c, COL_NUM);
            assign mask[PE] = row_match[r] &&
                              ((head_split.col == BCAST) ||
                               (head_split.col == id_word_t'(g_chain[PE].id)));
        end
    end

    // All-or-nothing: the head only leaves once every targeted PE is ready.
    assign deliver    = head_valid & ~bus.cfg_en;
    assign head_ready = ~bus.cfg_en & ((mask & ~bus.pe_ready) == '0);
    assign bus.pe_valid = deliver ? mask : '0;
    assign bus.pe_data  = head_word[DATA_BITWIDTH-1:0];
    assign bus.drop     = deliver & (mask == '0);

endmodule

// File: tb/tb_gin_mcast_net.sv
// Self-checking bench for gin_mcast_net: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_gin_mcast_net;

    localparam int DW    = 16;
    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int IDW   = 3;
    localparam int DEPTH = 4;
    localparam int N_PE  = ROWS * COLS;
    localparam int N_IDS = ROWS * (COLS + 1);
    localparam logic [IDW-1:0] BC = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [2*IDW-1:0] q_tag [$];
    logic [DW-1:0]    q_data[$];
    logic [IDW-1:0]   m_ids [N_IDS];

    gin_mcast_net_if #(
        .DATA_BITWIDTH (DW),
        .ROW_NUM       (ROWS),
        .COL_NUM       (COLS),
        .ID_BITWIDTH   (IDW),
        .FIFO_DEPTH    (DEPTH)
    ) bus ();

    gin_mcast_net #(
        .DATA_BITWIDTH (DW),
        .ROW_NUM       (ROWS),
        .COL_NUM       (COLS),
        .ID_BITWIDTH   (IDW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a word queue plus the scan-chain contents as a plain array.
    function automatic void model_reset();
        q_tag.delete();
        q_data.delete();
        for (int k = 0; k < N_IDS; k++)
            m_ids[k] = (k < N_PE) ? IDW'(k % COLS) : IDW'(k - N_PE);
    endfunction

    function automatic logic [N_PE-1:0] model_mask(input logic [2*IDW-1:0] tag);
        logic [IDW-1:0]  rt;
        logic [IDW-1:0]  ct;
        logic [N_PE-1:0] m;
        m  = '0;
        rt = tag[2*IDW-1:IDW];
        ct = tag[IDW-1:0];
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((rt == BC || rt == m_ids[N_PE + r]) && (ct == BC || ct == m_ids[r*COLS + c]))
                    m[r*COLS + c] = 1'b1;
        return m;
    endfunction

    task automatic set_idle();
        bus.valid    = 1'b0;
        bus.data     = '0;
        bus.tag      = '0;
        bus.cfg_en   = 1'b0;
        bus.cfg_data = '0;
        bus.pe_ready = '0;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit               do_pop;
        bit               do_push;
        bit               do_shift;
        logic [IDW-1:0]   sin;
        logic [2*IDW-1:0] t;
        logic [DW-1:0]    d;
        do_pop = 1'b0;
        if (q_tag.size() > 0 && !bus.cfg_en)
            do_pop = ((model_mask(q_tag[0]) & ~bus.pe_ready) == '0);
        do_push  = bus.valid && (q_tag.size() < DEPTH);
        do_shift = bus.cfg_en;
        sin = bus.cfg_data;
        t   = bus.tag;
        d   = bus.data;
        @(posedge clk);
        if (do_pop) begin
            void'(q_tag.pop_front());
            void'(q_data.pop_front());
        end
        if (do_push) begin
            q_tag.push_back(t);
            q_data.push_back(d);
        end
        if (do_shift) begin
            for (int k = N_IDS - 1; k > 0; k--) m_ids[k] = m_ids[k-1];
            m_ids[0] = sin;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [N_PE-1:0] exp_v;
        logic [DW-1:0]   d;
        rst_n = 1'b0;
        model_reset();
        bus.valid    = 1'b1;
        bus.data     = DW'($urandom);
        bus.tag      = (2*IDW)'($urandom);
        bus.cfg_en   = 1'($urandom);
        bus.cfg_data = IDW'($urandom);
        bus.pe_ready = {4'($urandom), $urandom};
        #1;
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got %b expected 1", bus.ready); end
        checks++; if (bus.pe_valid !== '0) begin failures++; $display("[TB] FAIL reset_pe_valid got %h expected 0", bus.pe_valid); end
        checks++; if (bus.count !== '0) begin failures++; $display("[TB] FAIL reset_count got %0d expected 0", bus.count); end
        checks++; if (bus.drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_drop got %b expected 0", bus.drop); end
        repeat (3) @(posedge clk);
        #1;
        bus.tag      = (2*IDW)'($urandom);
        bus.pe_ready = {4'($urandom), $urandom};
        #1;
        checks++; if (bus.count !== '0) begin failures++; $display("[TB] FAIL reset_held_count got %0d expected 0", bus.count); end
        checks++; if (bus.pe_valid !== '0) begin failures++; $display("[TB] FAIL reset_held_pe_valid got %h expected 0", bus.pe_valid); end
        set_idle();
        rst_n = 1'b1;
        #1;
        d = DW'($urandom);
        bus.valid = 1'b1;
        bus.tag   = {3'd2, 3'd3};
        bus.data  = d;
        tick();
        bus.valid = 1'b0;
        #1;
        exp_v = '0;
        exp_v[2*COLS + 3] = 1'b1;
        checks++; if (bus.pe_valid !== exp_v) begin failures++; $display("[TB] FAIL first_word_pe_valid got %h expected %h", bus.pe_valid, exp_v); end
        checks++; if (bus.pe_data !== d) begin failures++; $display("[TB] FAIL first_word_data got %h expected %h", bus.pe_data, d); end
    endtask

    task automatic test_unicast();
        bus.pe_ready = '1;
        #1;
        checks++; if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL unicast_count_before got %0d expected 1", bus.count); end
        checks++; if (bus.drop !== 1'b0) begin failures++; $display("[TB] FAIL unicast_drop got %b expected 0", bus.drop); end
        tick();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL unicast_count_after got %0d expected 0", bus.count); end
        checks++; if (bus.pe_valid !== '0) begin failures++; $display("[TB] FAIL unicast_pe_valid_after got %h expected 0", bus.pe_valid); end
    endtask

    task automatic test_row_mcast();
        logic [N_PE-1:0] exp_v;
        exp_v = '0;
        for (int r = 0; r < ROWS; r++) exp_v[r*COLS + 1] = 1'b1;
        bus.valid = 1'b1;
        bus.tag   = {BC, 3'd1};
        bus.data  = DW'($urandom);
        bus.pe_ready = '1;
        bus.pe_ready[19] = 1'b0;
        tick();
        bus.valid = 1'b0;
        #1;
        checks++; if (bus.pe_valid !== exp_v) begin failures++; $display("[TB] FAIL row_mcast_pe_valid got %h expected %h", bus.pe_valid, exp_v); end
        tick();
        checks++; if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL row_mcast_held_count got %0d expected 1", bus.count); end
        checks++; if (bus.pe_valid !== exp_v) begin failures++; $display("[TB] FAIL row_mcast_held_pe_valid got %h expected %h", bus.pe_valid, exp_v); end
        bus.pe_ready[19] = 1'b1;
        #1;
        checks++; if (bus.drop !== 1'b0) begin failures++; $display("[TB] FAIL row_mcast_drop got %b expected 0", bus.drop); end
        tick();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL row_mcast_pop_count got %0d expected 0", bus.count); end
    endtask

    task automatic test_drop();
        bus.valid    = 1'b1;
        bus.tag      = {3'd6, 3'd6};
        bus.data     = DW'($urandom);
        bus.pe_ready = '0;
        tick();
        bus.valid = 1'b0;
        #1;
        checks++; if (bus.drop !== 1'b1) begin failures++; $display("[TB] FAIL drop_pulse got %b expected 1", bus.drop); end
        checks++; if (bus.pe_valid !== '0) begin failures++; $display("[TB] FAIL drop_pe_valid got %h expected 0", bus.pe_valid); end
        tick();
        checks++; if (bus.drop !== 1'b0) begin failures++; $display("[TB] FAIL drop_after got %b expected 0", bus.drop); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL drop_count got %0d expected 0", bus.count); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [DEPTH];
        bus.pe_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = DW'($urandom);
            bus.valid = 1'b1;
            bus.tag   = {BC, BC};
            bus.data  = d[i];
            tick();
        end
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got %b expected 0", bus.ready); end
        checks++; if (bus.count !== 3'(DEPTH)) begin failures++; $display("[TB] FAIL full_count got %0d expected %0d", bus.count, DEPTH); end
        bus.data = DW'($urandom);
        tick();
        bus.valid = 1'b0;
        #1;
        checks++; if (bus.count !== 3'(DEPTH)) begin failures++; $display("[TB] FAIL full_reject_count got %0d expected %0d", bus.count, DEPTH); end
        bus.pe_ready = '1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++; if (bus.pe_valid !== {N_PE{1'b1}}) begin failures++; $display("[TB] FAIL drain_pe_valid word %0d got %h expected all ones", i, bus.pe_valid); end
            checks++; if (bus.pe_data !== d[i]) begin failures++; $display("[TB] FAIL drain_data word %0d got %h expected %h", i, bus.pe_data, d[i]); end
            tick();
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL drain_count got %0d expected 0", bus.count); end
    endtask

    task automatic test_reconfig();
        logic [DW-1:0] d;
        d = DW'($urandom);
        for (int k = 0; k < N_IDS; k++) begin
            bus.cfg_en   = 1'b1;
            bus.cfg_data = 3'd5;
            bus.valid    = (k == 0);
            bus.tag      = {3'd5, 3'd5};
            bus.data     = d;
            bus.pe_ready = '1;
            #1;
            if (k > 0) begin
                checks++; if (bus.pe_valid !== '0) begin failures++; $display("[TB] FAIL cfg_stall_pe_valid shift %0d got %h expected 0", k, bus.pe_valid); end
            end
            tick();
        end
        bus.cfg_en = 1'b0;
        bus.valid  = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd1) begin failures++; $display("[TB] FAIL cfg_push_count got %0d expected 1", bus.count); end
        checks++; if (bus.pe_valid !== {N_PE{1'b1}}) begin failures++; $display("[TB] FAIL cfg_new_ids_pe_valid got %h expected all ones", bus.pe_valid); end
        checks++; if (bus.pe_data !== d) begin failures++; $display("[TB] FAIL cfg_data_out got %h expected %h", bus.pe_data, d); end
        tick();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL cfg_pop_count got %0d expected 0", bus.count); end
    endtask

    task automatic test_reset_midflight();
        logic [N_PE-1:0] exp_v;
        bus.pe_ready = '0;
        for (int i = 0; i < 2; i++) begin
            bus.valid = 1'b1;
            bus.tag   = {BC, BC};
            bus.data  = DW'($urandom);
            tick();
        end
        bus.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL midreset_count got %0d expected 0", bus.count); end
        checks++; if (bus.pe_valid !== '0) begin failures++; $display("[TB] FAIL midreset_pe_valid got %h expected 0", bus.pe_valid); end
        rst_n = 1'b1;
        model_reset();
        bus.valid = 1'b1;
        bus.tag   = {3'd2, 3'd3};
        tick();
        bus.valid = 1'b0;
        #1;
        exp_v = '0;
        exp_v[2*COLS + 3] = 1'b1;
        checks++; if (bus.pe_valid !== exp_v) begin failures++; $display("[TB] FAIL midreset_ids_restored got %h expected %h", bus.pe_valid, exp_v); end
        bus.pe_ready = '1;
        tick();
    endtask

    task automatic test_random();
        logic [N_PE-1:0] m;
        logic [N_PE-1:0] exp_v;
        bit              busy;
        logic [IDW-1:0]  rt;
        logic [IDW-1:0]  ct;
        for (int n = 0; n < 400; n++) begin
            rt = ($urandom_range(0, 2) == 0) ? BC : IDW'($urandom_range(0, 7));
            ct = ($urandom_range(0, 2) == 0) ? BC : IDW'($urandom_range(0, 7));
            bus.cfg_en   = ($urandom_range(0, 15) == 0);
            bus.cfg_data = IDW'($urandom_range(0, 7));
            bus.valid    = 1'($urandom);
            bus.data     = DW'($urandom);
            bus.tag      = {rt, ct};
            bus.pe_ready = ($urandom_range(0, 3) != 0) ? {N_PE{1'b1}} : {4'($urandom), $urandom};
            #1;
            busy  = (q_tag.size() > 0) && !bus.cfg_en;
            m     = (q_tag.size() > 0) ? model_mask(q_tag[0]) : '0;
            exp_v = busy ? m : '0;
            checks++; if (bus.pe_valid !== exp_v) begin failures++; $display("[TB] FAIL rand_pe_valid cycle %0d got %h expected %h", n, bus.pe_valid, exp_v); end
            checks++; if (bus.drop !== (busy && m == '0)) begin failures++; $display("[TB] FAIL rand_drop cycle %0d got %b expected %b", n, bus.drop, (busy && m == '0)); end
            checks++; if (bus.ready !== (q_tag.size() < DEPTH)) begin failures++; $display("[TB] FAIL rand_ready cycle %0d got %b expected %b", n, bus.ready, (q_tag.size() < DEPTH)); end
            checks++; if (int'(bus.count) != q_tag.size()) begin failures++; $display("[TB] FAIL rand_count cycle %0d got %0d expected %0d", n, bus.count, q_tag.size()); end
            if (q_tag.size() > 0) begin
                checks++; if (bus.pe_data !== q_data[0]) begin failures++; $display("[TB] FAIL rand_data cycle %0d got %h expected %h", n, bus.pe_data, q_data[0]); end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_unicast();
        test_row_mcast();
        test_drop();
        test_back_to_back();
        test_reconfig();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
